// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory arbiter: owner tags and default widths.
package imem_pkg;

  typedef enum logic {OWN_FETCH = 1'b0, OWN_DBG = 1'b1} owner_e;

  localparam int IMEM_ADDR_W = 32;
  localparam int IMEM_DATA_W = 32;

endpackage

// File: rtl/owner_fifo.sv
// Ownership FIFO: remembers which requester issued each in-flight memory
// request so in-order responses can be steered back. Push is ignored when
// full and pop is ignored when empty, so count never over/underflows.
module owner_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  owner_e           i_push_owner,
  input  logic             i_pop,
  output owner_e           o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  owner_e           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage needs no reset: entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_owner;
  end

  // Pointers wrap modulo DEPTH (DEPTH need not fill the pointer range when 1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_count <= '0;
    else if (w_push && !w_pop) r_count <= r_count + 1'b1;
    else if (w_pop && !w_push) r_count <= r_count - 1'b1;
  end

endmodule

// File: rtl/imem_arbiter.sv
// Two-requester arbiter (fetch=0, debug=1) in front of the single imem port.
// Requests pass through combinationally; an ownership FIFO routes in-order
// responses back. Define IMEM_ARB_RR_EN for round-robin arbitration;
// otherwise fetch has fixed priority over debug.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = IMEM_ADDR_W,
  parameter int DATA_W          = IMEM_DATA_W,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            m_req_valid,
  output logic [1:0]            m_req_ready,
  input  logic [1:0][ADDR_W-1:0] m_req_addr,
  output logic [1:0]            m_resp_valid,
  input  logic [1:0]            m_resp_ready,
  output logic [DATA_W-1:0]     m_resp_data,
  output logic                  s_req_valid,
  input  logic                  s_req_ready,
  output logic [ADDR_W-1:0]     s_req_addr,
  input  logic                  s_resp_valid,
  output logic                  s_resp_ready,
  input  logic [DATA_W-1:0]     s_resp_data,
  output logic [CNT_W-1:0]      outstanding,
  output logic                  err_unexp_resp
);

  logic   r_lock;
  logic   r_lock_id;
  logic   r_last_grant;
  logic   r_err;
  logic   w_grant;
  logic   w_full;
  logic   w_empty;
  logic   w_req_fire;
  logic   w_resp_fire;
  logic   w_head_id;
  owner_e w_head;

  // Grant select: an outstanding stalled request keeps its grant so the
  // address stays stable until it fires; otherwise apply the policy.
  always_comb begin
    w_grant = 1'b0;
    if (r_lock) begin
      w_grant = r_lock_id;
    end else begin
`ifdef IMEM_ARB_RR_EN
      if (m_req_valid == 2'b11) w_grant = ~r_last_grant;
      else                      w_grant = !m_req_valid[0] && m_req_valid[1];
`else
      w_grant = !m_req_valid[0] && m_req_valid[1];
`endif
    end
  end

  assign s_req_valid = m_req_valid[w_grant] && !w_full;
  assign s_req_addr  = m_req_addr[w_grant];
  assign w_req_fire  = s_req_valid && s_req_ready;

  // Only the granted requester can see ready; nothing is accepted while full.
  always_comb begin
    m_req_ready          = 2'b00;
    m_req_ready[w_grant] = s_req_ready && !w_full;
  end

  assign w_head_id    = (w_head == OWN_DBG);
  assign s_resp_ready = m_resp_ready[w_head_id] && !w_empty;
  assign w_resp_fire  = s_resp_valid && s_resp_ready;
  assign m_resp_data  = s_resp_data;

  // Response steering to the FIFO head owner.
  always_comb begin
    m_resp_valid            = 2'b00;
    m_resp_valid[w_head_id] = s_resp_valid && !w_empty;
  end

  // Lock tracking and last-grant history (history only steers round-robin).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock       <= 1'b0;
      r_lock_id    <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_lock       <= s_req_valid && !s_req_ready;
      r_lock_id    <= w_grant;
      r_last_grant <= w_req_fire ? w_grant : r_last_grant;
    end
  end

  // Sticky flag for a response that has no owner to go to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        r_err <= 1'b0;
    else if (s_resp_valid && w_empty) r_err <= 1'b1;
  end

  assign err_unexp_resp = r_err;

  owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_owner_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_req_fire),
    .i_push_owner (owner_e'(w_grant)),
    .i_pop        (w_resp_fire),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (outstanding)
  );

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter (MAX_OUTSTANDING=2). Inputs change 1ns after
// the rising edge; outputs are checked 1ns later, well before the next edge.
module tb_imem_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       m_req_valid, m_req_ready, m_resp_valid, m_resp_ready;
  logic [1:0][31:0] m_req_addr;
  logic [31:0]      m_resp_data;
  logic             s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;
  logic [31:0]      s_req_addr, s_resp_data;
  logic [1:0]       outstanding;
  logic             err_unexp_resp;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.MAX_OUTSTANDING(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_resp_data(m_resp_data),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp_data(s_resp_data),
    .outstanding(outstanding), .err_unexp_resp(err_unexp_resp)
  );

  task automatic clear_inputs();
    m_req_valid  = 2'b00;
    m_req_addr[0] = 32'h100;
    m_req_addr[1] = 32'h200;
    m_resp_ready = 2'b11;
    s_req_ready  = 1'b0;
    s_resp_valid = 1'b0;
    s_resp_data  = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++; if (s_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_s_req_valid got=%b exp=0", s_req_valid); end
    n_chk++; if (m_req_ready !== 2'b00) begin n_err++; $display("FAIL rst_m_req_ready got=%b exp=00", m_req_ready); end
    n_chk++; if (m_resp_valid !== 2'b00) begin n_err++; $display("FAIL rst_m_resp_valid got=%b exp=00", m_resp_valid); end
    n_chk++; if (s_resp_ready !== 1'b0) begin n_err++; $display("FAIL rst_s_resp_ready got=%b exp=0", s_resp_ready); end
    n_chk++; if (outstanding !== 2'd0) begin n_err++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding); end
    n_chk++; if (err_unexp_resp !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b exp=0", err_unexp_resp); end
    step();
  endtask

  // Fetch stream 0x0,0x4,0x8 with 1-cycle responses 0xA,0xB,0xC.
  task automatic test_fetch_stream();
    s_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_req_valid   = (k < 3) ? 2'b01 : 2'b00;
      m_req_addr[0] = 32'(k * 4);
      s_resp_valid  = (k > 0);
      s_resp_data   = 32'hA + 32'(k) - 32'd1;
      #1;
      if (k < 3) begin
        n_chk++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'(k * 4)) begin n_err++; $display("FAIL fs_req k=%0d got v=%b a=%h exp v=1 a=%h", k, s_req_valid, s_req_addr, k * 4); end
        n_chk++; if (m_req_ready !== 2'b01) begin n_err++; $display("FAIL fs_m_req_ready k=%0d got=%b exp=01", k, m_req_ready); end
      end
      if (k > 0) begin
        n_chk++; if (m_resp_valid !== 2'b01 || m_resp_data !== 32'hA + 32'(k) - 32'd1) begin n_err++; $display("FAIL fs_resp k=%0d got v=%b d=%h exp v=01 d=%h", k, m_resp_valid, m_resp_data, 32'hA + k - 1); end
      end
      n_chk++; if (outstanding !== ((k > 0) ? 2'd1 : 2'd0)) begin n_err++; $display("FAIL fs_outstanding k=%0d got=%0d exp=%0d", k, outstanding, (k > 0) ? 1 : 0); end
      step();
    end
    clear_inputs();
    #1;
    n_chk++; if (outstanding !== 2'd0) begin n_err++; $display("FAIL fs_drain got=%0d exp=0", outstanding); end
    step();
  endtask

  // Both requesters valid every cycle, responses returned the next cycle.
  task automatic test_arbitration();
    logic [1:0] exp_rdy;
    logic [1:0] prev_rdy;
    do_reset();
    s_req_ready = 1'b1;
    prev_rdy    = 2'b00;
    for (int k = 0; k < 5; k++) begin
      m_req_valid  = (k < 4) ? 2'b11 : 2'b00;
      s_resp_valid = (k > 0);
      s_resp_data  = 32'h50 + 32'(k);
`ifdef IMEM_ARB_RR_EN
      exp_rdy = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
      exp_rdy = 2'b01;
`endif
      #1;
      if (k < 4) begin
        n_chk++; if (m_req_ready !== exp_rdy) begin n_err++; $display("FAIL arb_grant k=%0d got=%b exp=%b", k, m_req_ready, exp_rdy); end
        n_chk++; if (s_req_addr !== ((exp_rdy == 2'b10) ? 32'h200 : 32'h100)) begin n_err++; $display("FAIL arb_addr k=%0d got=%h", k, s_req_addr); end
      end
      if (k > 0) begin
        n_chk++; if (m_resp_valid !== prev_rdy) begin n_err++; $display("FAIL arb_route k=%0d got=%b exp=%b", k, m_resp_valid, prev_rdy); end
      end
      prev_rdy = exp_rdy;
      step();
    end
    clear_inputs();
    #1;
    n_chk++; if (outstanding !== 2'd0) begin n_err++; $display("FAIL arb_drain got=%0d exp=0", outstanding); end
    step();
  endtask

  // Debug granted and stalled 3 cycles; fetch raises valid meanwhile.
  task automatic test_lock();
    for (int k = 0; k < 5; k++) begin
      m_req_valid = (k == 0) ? 2'b10 : 2'b11;
      s_req_ready = (k >= 3);
      #1;
      if (k < 4) begin
        n_chk++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h200) begin n_err++; $display("FAIL lock_hold k=%0d got v=%b a=%h exp v=1 a=00000200", k, s_req_valid, s_req_addr); end
        n_chk++; if (m_req_ready !== ((k == 3) ? 2'b10 : 2'b00)) begin n_err++; $display("FAIL lock_ready k=%0d got=%b", k, m_req_ready); end
      end else begin
        n_chk++; if (m_req_ready !== 2'b01 || s_req_addr !== 32'h100) begin n_err++; $display("FAIL lock_after got rdy=%b a=%h exp rdy=01 a=00000100", m_req_ready, s_req_addr); end
      end
      step();
    end
    m_req_valid = 2'b00;
    s_req_ready = 1'b0;
    s_resp_valid = 1'b1;
    #1;
    n_chk++; if (m_resp_valid !== 2'b10) begin n_err++; $display("FAIL lock_resp1 got=%b exp=10", m_resp_valid); end
    step();
    #1;
    n_chk++; if (m_resp_valid !== 2'b01) begin n_err++; $display("FAIL lock_resp2 got=%b exp=01", m_resp_valid); end
    step();
    clear_inputs();
    step();
  endtask

  // Memory withholds responses: third request must wait for the first response.
  task automatic test_full();
    s_req_ready = 1'b1;
    m_req_valid = 2'b01;
    step();
    step();
    #1;
    n_chk++; if (outstanding !== 2'd2) begin n_err++; $display("FAIL full_count got=%0d exp=2", outstanding); end
    n_chk++; if (s_req_valid !== 1'b0 || m_req_ready !== 2'b00) begin n_err++; $display("FAIL full_block got v=%b rdy=%b exp v=0 rdy=00", s_req_valid, m_req_ready); end
    step();
    s_resp_valid = 1'b1;
    #1;
    n_chk++; if (s_req_valid !== 1'b0 || s_resp_ready !== 1'b1) begin n_err++; $display("FAIL full_pop_same got sv=%b srr=%b exp sv=0 srr=1", s_req_valid, s_resp_ready); end
    step();
    #1;
    n_chk++; if (s_req_valid !== 1'b1 || m_req_ready !== 2'b01 || outstanding !== 2'd1) begin n_err++; $display("FAIL full_resume got v=%b rdy=%b cnt=%0d exp v=1 rdy=01 cnt=1", s_req_valid, m_req_ready, outstanding); end
    step();
    m_req_valid = 2'b00;
    #1;
    n_chk++; if (outstanding !== 2'd1) begin n_err++; $display("FAIL full_pushpop got=%0d exp=1", outstanding); end
    step();
    clear_inputs();
    #1;
    n_chk++; if (outstanding !== 2'd0) begin n_err++; $display("FAIL full_drain got=%0d exp=0", outstanding); end
    step();
  endtask

  // Grants 0,1,0 with responses 0x11,0x22,0x33; debug back-pressures 0x22.
  task automatic test_routing();
    s_req_ready = 1'b1;
    m_req_valid = 2'b01;
    step();
    m_req_valid = 2'b10; s_resp_valid = 1'b1; s_resp_data = 32'h11;
    #1;
    n_chk++; if (m_resp_valid !== 2'b01 || m_resp_data !== 32'h11) begin n_err++; $display("FAIL rt_r0 got v=%b d=%h exp v=01 d=11", m_resp_valid, m_resp_data); end
    step();
    m_req_valid = 2'b01; s_resp_data = 32'h22; m_resp_ready = 2'b01;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_chk++; if (m_resp_valid !== 2'b10 || s_resp_ready !== 1'b0 || m_resp_data !== 32'h22) begin n_err++; $display("FAIL rt_hold k=%0d got v=%b srr=%b d=%h exp v=10 srr=0 d=22", k, m_resp_valid, s_resp_ready, m_resp_data); end
      step();
      m_req_valid = 2'b00;
    end
    m_resp_ready = 2'b11;
    #1;
    n_chk++; if (s_resp_ready !== 1'b1 || outstanding !== 2'd2) begin n_err++; $display("FAIL rt_r1 got srr=%b cnt=%0d exp srr=1 cnt=2", s_resp_ready, outstanding); end
    step();
    s_resp_data = 32'h33;
    #1;
    n_chk++; if (m_resp_valid !== 2'b01 || m_resp_data !== 32'h33) begin n_err++; $display("FAIL rt_r2 got v=%b d=%h exp v=01 d=33", m_resp_valid, m_resp_data); end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_unexp_resp();
    s_resp_valid = 1'b1;
    #1;
    n_chk++; if (s_resp_ready !== 1'b0 || m_resp_valid !== 2'b00) begin n_err++; $display("FAIL ux_ready got srr=%b mrv=%b exp srr=0 mrv=00", s_resp_ready, m_resp_valid); end
    step();
    s_resp_valid = 1'b0;
    step();
    step();
    n_chk++; if (err_unexp_resp !== 1'b1) begin n_err++; $display("FAIL ux_sticky got=%b exp=1", err_unexp_resp); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    n_chk++; if (err_unexp_resp !== 1'b0) begin n_err++; $display("FAIL rm_err_clr got=%b exp=0", err_unexp_resp); end
    s_req_ready = 1'b1;
    m_req_valid = 2'b01;
    step();
    step();
    n_chk++; if (outstanding !== 2'd2) begin n_err++; $display("FAIL rm_pre got=%0d exp=2", outstanding); end
    #2;
    reset = 1'b1;
    clear_inputs();
    #1;
    n_chk++; if (outstanding !== 2'd0 || s_req_valid !== 1'b0 || m_req_ready !== 2'b00 || m_resp_valid !== 2'b00 || s_resp_ready !== 1'b0 || err_unexp_resp !== 1'b0) begin
      n_err++; $display("FAIL rm_async got cnt=%0d sv=%b mrr=%b mrv=%b srr=%b err=%b exp all 0", outstanding, s_req_valid, m_req_ready, m_resp_valid, s_resp_ready, err_unexp_resp);
    end
    step();
    reset = 1'b0;
    s_resp_valid = 1'b1;
    #1;
    n_chk++; if (s_resp_ready !== 1'b0) begin n_err++; $display("FAIL rm_stale_ready got=%b exp=0", s_resp_ready); end
    step();
    s_resp_valid = 1'b0;
    #1;
    n_chk++; if (err_unexp_resp !== 1'b1) begin n_err++; $display("FAIL rm_stale_err got=%b exp=1", err_unexp_resp); end
  endtask

  initial begin
    test_reset();
    test_fetch_stream();
    test_arbitration();
    test_lock();
    test_full();
    test_routing();
    test_unexp_resp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
